// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings and widths for the pipeline control unit.
package pipeline_ctrl_pkg;

   localparam int REG_IDX_W    = 5;
   localparam int WAIT_CNT_W   = 16;
   localparam int BUBBLE_CNT_W = 3;
   localparam int PERF_CNT_W   = 32;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_REDIRECT = 2'd2
   } ctrl_state_e;

endpackage

// File: rtl/load_use_detector.sv
// Flags a read-after-load hazard between the ID instruction and the load in EX.
module load_use_detector
   import pipeline_ctrl_pkg::*;
(
   input  logic [REG_IDX_W-1:0] id_rs1,
   input  logic [REG_IDX_W-1:0] id_rs2,
   input  logic                 id_uses_rs1,
   input  logic                 id_uses_rs2,
   input  logic [REG_IDX_W-1:0] ex_rd,
   input  logic                 ex_memory_read,
   output logic                 load_use
);

   // x0 is hardwired to zero, so a load targeting it never creates a hazard.
   assign load_use = ex_memory_read && (ex_rd != '0) &&
                     ((id_uses_rs1 && (ex_rd == id_rs1)) ||
                      (id_uses_rs2 && (ex_rd == id_rs2)));

endmodule

// File: rtl/pipeline_control_unit.sv
// Stall/flush/redirect controller for a 5-stage pipeline with a MEM_WAIT watchdog.
// Optional perf counters are enabled by defining PIPELINE_PERF_COUNTERS_EN.
module pipeline_control_unit
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned REDIRECT_BUBBLES = 1,
   parameter int unsigned MEM_TIMEOUT      = 255
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [REG_IDX_W-1:0] ID_rs1,
   input  logic [REG_IDX_W-1:0] ID_rs2,
   input  logic                 ID_uses_rs1,
   input  logic                 ID_uses_rs2,
   input  logic [REG_IDX_W-1:0] EX_rd,
   input  logic                 EX_memory_read,
   input  logic                 EX_redirect_req,
   input  logic                 dmem_busy,
   output logic                 pc_stall,
   output logic                 pc_redirect,
   output logic                 IF_ID_stall,
   output logic                 IF_ID_flush,
   output logic                 ID_EX_stall,
   output logic                 ID_EX_flush,
   output logic                 EX_MEM_stall,
   output logic                 MEM_WB_flush,
   output logic                 mem_timeout_err,
   output logic [1:0]           ctrl_state
`ifdef PIPELINE_PERF_COUNTERS_EN
   ,
   output logic [PERF_CNT_W-1:0] stall_cycles,
   output logic [PERF_CNT_W-1:0] flush_events
`endif
);

   localparam logic [BUBBLE_CNT_W-1:0] BUBBLE_LOAD = BUBBLE_CNT_W'(REDIRECT_BUBBLES);
   localparam logic [WAIT_CNT_W-1:0]   TIMEOUT_LIM = WAIT_CNT_W'(MEM_TIMEOUT);

   ctrl_state_e              state_q, state_d;
   logic [BUBBLE_CNT_W-1:0]  bubble_q, bubble_d;
   logic [WAIT_CNT_W-1:0]    wait_q, wait_d;
   logic                     redirect_pending_q, redirect_pending_d;
   logic                     err_q, err_d;
   logic                     load_use;
   logic                     take_redirect;
   logic                     check_load_use;

   load_use_detector u_load_use_detector (
      .id_rs1         (ID_rs1),
      .id_rs2         (ID_rs2),
      .id_uses_rs1    (ID_uses_rs1),
      .id_uses_rs2    (ID_uses_rs2),
      .ex_rd          (EX_rd),
      .ex_memory_read (EX_memory_read),
      .load_use       (load_use)
   );

   always_comb begin
      pc_stall           = 1'b0;
      pc_redirect        = 1'b0;
      IF_ID_stall        = 1'b0;
      IF_ID_flush        = 1'b0;
      ID_EX_stall        = 1'b0;
      ID_EX_flush        = 1'b0;
      EX_MEM_stall       = 1'b0;
      MEM_WB_flush       = 1'b0;
      state_d            = state_q;
      bubble_d           = bubble_q;
      wait_d             = '0;
      redirect_pending_d = redirect_pending_q;
      err_d              = err_q;
      take_redirect      = 1'b0;
      check_load_use     = 1'b0;

      if (reset) begin
         IF_ID_flush  = 1'b1;
         ID_EX_flush  = 1'b1;
         MEM_WB_flush = 1'b1;
      end else if (dmem_busy) begin
         // Freeze everything up to MEM; a redirect seen now is replayed on release.
         pc_stall           = 1'b1;
         IF_ID_stall        = 1'b1;
         ID_EX_stall        = 1'b1;
         EX_MEM_stall       = 1'b1;
         MEM_WB_flush       = 1'b1;
         state_d            = ST_MEM_WAIT;
         bubble_d           = '0;
         redirect_pending_d = redirect_pending_q | EX_redirect_req;
         wait_d             = (&wait_q) ? wait_q : wait_q + WAIT_CNT_W'(1);
         if (wait_d >= TIMEOUT_LIM)
            err_d = 1'b1;
      end else begin
         case (state_q)
            ST_RUN: begin
               state_d        = ST_RUN;
               take_redirect  = EX_redirect_req;
               check_load_use = 1'b1;
            end
            ST_MEM_WAIT: begin
               state_d            = ST_RUN;
               take_redirect      = redirect_pending_q | EX_redirect_req;
               check_load_use     = 1'b1;
               redirect_pending_d = 1'b0;
            end
            ST_REDIRECT: begin
               if (EX_redirect_req) begin
                  take_redirect = 1'b1;
               end else begin
                  IF_ID_flush = 1'b1;
                  ID_EX_flush = 1'b1;
                  if (bubble_q <= BUBBLE_CNT_W'(1)) begin
                     state_d  = ST_RUN;
                     bubble_d = '0;
                  end else begin
                     bubble_d = bubble_q - BUBBLE_CNT_W'(1);
                  end
               end
            end
            default: state_d = ST_RUN;
         endcase

         if (take_redirect) begin
            pc_redirect = 1'b1;
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
            if (REDIRECT_BUBBLES > 0) begin
               state_d  = ST_REDIRECT;
               bubble_d = BUBBLE_LOAD;
            end else begin
               state_d  = ST_RUN;
               bubble_d = '0;
            end
         end else if (check_load_use && load_use) begin
            pc_stall    = 1'b1;
            IF_ID_stall = 1'b1;
            ID_EX_flush = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q            <= ST_RUN;
         bubble_q           <= '0;
         wait_q             <= '0;
         redirect_pending_q <= 1'b0;
         err_q              <= 1'b0;
      end else begin
         state_q            <= state_d;
         bubble_q           <= bubble_d;
         wait_q             <= wait_d;
         redirect_pending_q <= redirect_pending_d;
         err_q              <= err_d;
      end
   end

   assign mem_timeout_err = err_q;
   assign ctrl_state      = state_q;

`ifdef PIPELINE_PERF_COUNTERS_EN
   logic [PERF_CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [PERF_CNT_W-1:0] flush_events_q, flush_events_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q + PERF_CNT_W'(pc_stall);
      flush_events_d = flush_events_q + PERF_CNT_W'(pc_redirect);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles_q <= '0;
         flush_events_q <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_events_q <= flush_events_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_pipeline_control_unit;

   localparam int RB = 2;
   localparam int MT = 3;

   logic       clk;
   logic       reset;
   logic [4:0] ID_rs1, ID_rs2, EX_rd;
   logic       ID_uses_rs1, ID_uses_rs2, EX_memory_read, EX_redirect_req, dmem_busy;
   logic       pc_stall, pc_redirect, IF_ID_stall, IF_ID_flush;
   logic       ID_EX_stall, ID_EX_flush, EX_MEM_stall, MEM_WB_flush;
   logic       mem_timeout_err;
   logic [1:0] ctrl_state;
`ifdef PIPELINE_PERF_COUNTERS_EN
   logic [31:0] stall_cycles, flush_events;
`endif

   pipeline_control_unit #(.REDIRECT_BUBBLES(RB), .MEM_TIMEOUT(MT)) dut (
      .clk             (clk),
      .reset           (reset),
      .ID_rs1          (ID_rs1),
      .ID_rs2          (ID_rs2),
      .ID_uses_rs1     (ID_uses_rs1),
      .ID_uses_rs2     (ID_uses_rs2),
      .EX_rd           (EX_rd),
      .EX_memory_read  (EX_memory_read),
      .EX_redirect_req (EX_redirect_req),
      .dmem_busy       (dmem_busy),
      .pc_stall        (pc_stall),
      .pc_redirect     (pc_redirect),
      .IF_ID_stall     (IF_ID_stall),
      .IF_ID_flush     (IF_ID_flush),
      .ID_EX_stall     (ID_EX_stall),
      .ID_EX_flush     (ID_EX_flush),
      .EX_MEM_stall    (EX_MEM_stall),
      .MEM_WB_flush    (MEM_WB_flush),
      .mem_timeout_err (mem_timeout_err),
      .ctrl_state      (ctrl_state)
`ifdef PIPELINE_PERF_COUNTERS_EN
      ,
      .stall_cycles    (stall_cycles),
      .flush_events    (flush_events)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int testsRun = 0;
   int testsFailed = 0;

   // Model state: frozen-by-memory flag, remaining flush bubbles, pending redirect, watchdog.
   bit          mInWait, mPending, mErr;
   int          mBubbles, mWait;
   bit [31:0]   mStalls, mRedirs;

   logic [7:0]  obsVec;
   logic [1:0]  obsState;
   logic        obsErr;

   task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input bit rst, input bit busy, input bit redir, input bit mr,
                                input bit u1, input bit u2, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2);
      reset           = rst;
      dmem_busy       = busy;
      EX_redirect_req = redir;
      EX_memory_read  = mr;
      ID_uses_rs1     = u1;
      ID_uses_rs2     = u2;
      EX_rd           = rd;
      ID_rs1          = rs1;
      ID_rs2          = rs2;
   endtask

   // Outputs are packed as {pc_stall,pc_redirect,IF_ID_stall,IF_ID_flush,ID_EX_stall,ID_EX_flush,EX_MEM_stall,MEM_WB_flush}.
   task automatic checkOutput();
      logic [7:0] expVec;
      logic [1:0] expState;
      bit         lu, take;
      expState = mInWait ? 2'd1 : (mBubbles > 0 ? 2'd2 : 2'd0);
      lu = EX_memory_read && EX_rd != 0 &&
           ((ID_uses_rs1 && EX_rd == ID_rs1) || (ID_uses_rs2 && EX_rd == ID_rs2));
      obsVec   = {pc_stall, pc_redirect, IF_ID_stall, IF_ID_flush,
                  ID_EX_stall, ID_EX_flush, EX_MEM_stall, MEM_WB_flush};
      obsState = ctrl_state;
      obsErr   = mem_timeout_err;

      if (reset)                                     expVec = 8'h15;
      else if (dmem_busy)                            expVec = 8'hAB;
      else if (!mInWait && mBubbles > 0 && !EX_redirect_req) expVec = 8'h14;
      else begin
         take = EX_redirect_req || (mInWait && mPending);
         expVec = take ? 8'h54 : (lu ? 8'hA4 : 8'h00);
      end

      compare("controls", {24'd0, obsVec}, {24'd0, expVec});
      compare("ctrl_state", {30'd0, obsState}, {30'd0, expState});
      compare("mem_timeout_err", {31'd0, obsErr}, {31'd0, mErr});
`ifdef PIPELINE_PERF_COUNTERS_EN
      compare("stall_cycles", stall_cycles, mStalls);
      compare("flush_events", flush_events, mRedirs);
`endif

      if (reset) begin
         mInWait = 0; mPending = 0; mErr = 0; mBubbles = 0; mWait = 0;
         mStalls = 0; mRedirs = 0;
      end else begin
         mStalls += {31'd0, expVec[7]};
         mRedirs += {31'd0, expVec[6]};
         if (dmem_busy) begin
            mPending = mPending | EX_redirect_req;
            if (mWait < 65535) mWait++;
            if (mWait >= MT) mErr = 1;
            mInWait  = 1;
            mBubbles = 0;
         end else begin
            mWait = 0;
            if (expVec == 8'h14) mBubbles--;
            else begin
               mBubbles = expVec[6] ? RB : 0;
               mInWait  = 0;
               mPending = 0;
            end
         end
      end
   endtask

   task automatic step(input bit rst, input bit busy, input bit redir, input bit mr,
                       input bit u1, input bit u2, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
      applyStimulus(rst, busy, redir, mr, u1, u2, rd, rs1, rs2);
      #3;
      checkOutput();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
   endtask

   task automatic doReset();
      step(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
   endtask

   int busyLeft;

   initial begin
      applyStimulus(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      @(posedge clk);
      #1;
      mInWait = 0; mPending = 0; mErr = 0; mBubbles = 0; mWait = 0; mStalls = 0; mRedirs = 0;

      doReset();
      compare("reset flushes", {24'd0, obsVec}, 32'h15);
      compare("reset state", {30'd0, obsState}, 32'd0);

      // Load-use on rs1, then a clean cycle.
      step(0, 0, 0, 1, 1, 0, 5'd5, 5'd5, 5'd9);
      compare("load-use stall", {24'd0, obsVec}, 32'hA4);
      idle();
      compare("after load-use", {24'd0, obsVec}, 32'h00);

      step(0, 0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd9);
      compare("load-use rd0", {24'd0, obsVec}, 32'h00);
      step(0, 0, 0, 1, 0, 0, 5'd5, 5'd5, 5'd9);
      compare("load-use unused rs1", {24'd0, obsVec}, 32'h00);

      // Redirect followed by two bubbles.
      step(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      compare("redirect ctrl", {24'd0, obsVec}, 32'h54);
      compare("redirect st0", {30'd0, obsState}, 32'd0);
      idle();
      compare("bubble1 ctrl", {24'd0, obsVec}, 32'h14);
      compare("bubble1 st", {30'd0, obsState}, 32'd2);
      idle();
      compare("bubble2 ctrl", {24'd0, obsVec}, 32'h14);
      compare("bubble2 st", {30'd0, obsState}, 32'd2);
      idle();
      compare("post-redirect st", {30'd0, obsState}, 32'd0);
      compare("post-redirect ctrl", {24'd0, obsVec}, 32'h00);

      // Four-cycle freeze with a redirect captured in cycle 2.
      step(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      compare("freeze1", {24'd0, obsVec}, 32'hAB);
      step(0, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      compare("freeze2 st", {30'd0, obsState}, 32'd1);
      step(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      step(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      compare("freeze4", {24'd0, obsVec}, 32'hAB);
      idle();
      compare("pending redirect", {24'd0, obsVec}, 32'h54);
      idle();
      idle();
      idle();
      step(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      idle();
      compare("pending cleared", {24'd0, obsVec}, 32'h00);

      // Watchdog with MEM_TIMEOUT=3.
      doReset();
      for (int i = 1; i <= 5; i++) begin
         step(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
         compare($sformatf("timeout wait%0d", i), {31'd0, obsErr}, (i >= 4) ? 32'd1 : 32'd0);
      end
      idle();
      compare("timeout sticky", {31'd0, obsErr}, 32'd1);

      // Reset while in REDIRECT discards the remaining bubbles.
      doReset();
      step(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      idle();
      compare("in redirect", {30'd0, obsState}, 32'd2);
      doReset();
      compare("reset in redirect", {24'd0, obsVec}, 32'h15);
      idle();
      compare("release st", {30'd0, obsState}, 32'd0);
      compare("release ctrl", {24'd0, obsVec}, 32'h00);

      // Random traffic.
      busyLeft = 0;
      for (int c = 0; c < 3000; c++) begin
         bit rb, rr, rst;
         rst = ($urandom_range(0, 63) == 0);
         if (busyLeft > 0) begin
            rb = 1;
            busyLeft--;
         end else if ($urandom_range(0, 7) == 0) begin
            rb = 1;
            busyLeft = $urandom_range(0, 5);
         end else begin
            rb = 0;
         end
         rr = ($urandom_range(0, 5) == 0);
         step(rst, rb, rr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
